// File: rtl/memory_access_stage.sv
// Memory stage: one load or store per instruction against a multi-cycle memory
// with a stall/done handshake, plus misalignment and timeout error pulses.
module memory_access_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inXOut,
  input  logic [15:0] inWriteData,
  input  logic        inMemoryRead,
  input  logic        inMemoryWrite,
  input  logic        memStall,
  input  logic        memDone,
  input  logic [15:0] memDataOut,
  output logic [15:0] memAddr,
  output logic [15:0] memDataIn,
  output logic        memRead,
  output logic        memWrite,
  output logic [15:0] outMemoryOut,
  output logic        outStall,
  output logic        outErr,
  output logic [1:0]  o_dbg_state
);

  // Memory handshake: the request (memRead/memWrite with memAddr/memDataIn)
  // is offered in REQ and accepted on the first edge where memStall=0;
  // memDone is a one-cycle completion pulse honoured only while the access
  // is outstanding (REQ with memStall=0, or WAIT).
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [15:0] r_addr;
  logic [15:0] r_data;
  logic        r_rd;
  logic        r_wr;
  logic [15:0] r_load;
  logic [7:0]  r_tcnt;

  logic w_idle, w_req, w_wait, w_done, w_busy;
  logic w_op, w_misaligned, w_accept, w_complete, w_timeout;

  assign w_idle = (r_state == S_IDLE);
  assign w_req  = (r_state == S_REQ);
  assign w_wait = (r_state == S_WAIT);
  assign w_done = (r_state == S_DONE);
  assign w_busy = w_req | w_wait;

  assign w_op         = inMemoryRead | inMemoryWrite;
  assign w_misaligned = w_idle & w_op & inXOut[0];
  assign w_accept     = w_idle & w_op & ~inXOut[0];
  assign w_complete   = (w_req & ~memStall & memDone) | (w_wait & memDone);
  // A completion in the last allowed cycle wins over the timeout.
  assign w_timeout    = w_busy & (r_tcnt == TO_LAST) & ~w_complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_load  <= '0;
      r_tcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= inXOut;
            r_data  <= inWriteData;
            r_rd    <= inMemoryRead;
            r_wr    <= inMemoryWrite;
            r_tcnt  <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ, S_WAIT: begin
          r_tcnt <= r_tcnt + 8'd1;
          if (w_complete) begin
            r_load  <= r_rd ? memDataOut : 16'h0000;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_load  <= '0;
            r_state <= S_DONE;
          end else if (w_req && !memStall) begin
            r_state <= S_WAIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    memAddr      = w_req ? r_addr : 16'h0000;
    memDataIn    = w_req ? r_data : 16'h0000;
    memRead      = w_req & r_rd;
    memWrite     = w_req & r_wr;
    outMemoryOut = w_done ? r_load : 16'h0000;
    outStall     = w_accept | w_busy;
    outErr       = w_misaligned | w_timeout;
    o_dbg_state  = r_state;
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: drivers push expected responses,
// a negedge monitor pops and compares each DONE or error event.
module tb_memory_access_stage;

  localparam int W = 75;
  localparam logic [1:0] K_ERR  = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;
  localparam logic [1:0] S_IDLE = 2'd0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] inXOut = '0;
  logic [15:0] inWriteData = '0;
  logic        inMemoryRead = 1'b0;
  logic        inMemoryWrite = 1'b0;
  logic        memStall = 1'b0;
  logic        memDone = 1'b0;
  logic [15:0] memDataOut = '0;
  logic [15:0] memAddr;
  logic [15:0] memDataIn;
  logic        memRead;
  logic        memWrite;
  logic [15:0] outMemoryOut;
  logic        outStall;
  logic        outErr;
  logic [1:0]  o_dbg_state;

  memory_access_stage #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .inXOut(inXOut), .inWriteData(inWriteData),
    .inMemoryRead(inMemoryRead), .inMemoryWrite(inMemoryWrite),
    .memStall(memStall), .memDone(memDone), .memDataOut(memDataOut),
    .memAddr(memAddr), .memDataIn(memDataIn), .memRead(memRead),
    .memWrite(memWrite), .outMemoryOut(outMemoryOut), .outStall(outStall),
    .outErr(outErr), .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int n_events = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Record: {hold_bad, kind, stall cycles, memRead cycles, memWrite cycles, addr, wdata, outMemoryOut}
  function automatic logic [W-1:0] mk(input logic [1:0] kind, input logic [7:0] st,
                                      input logic [7:0] rd, input logic [7:0] wr,
                                      input logic [15:0] a, input logic [15:0] d,
                                      input logic [15:0] q);
    return {1'b0, kind, st, rd, wr, a, d, q};
  endfunction

  // Monitor: accumulates per-transaction activity and compares on each event.
  logic [7:0]  m_stall, m_rd, m_wr;
  logic [15:0] m_addr, m_wd;
  logic        m_hold_bad;
  logic [W-1:0] m_got, m_exp;

  always @(negedge clk) begin
    if (rst) begin
      m_stall = 0; m_rd = 0; m_wr = 0; m_addr = 0; m_wd = 0; m_hold_bad = 0;
    end else begin
      if (outStall) m_stall = m_stall + 8'd1;
      if (memRead || memWrite) begin
        if (m_rd == 0 && m_wr == 0) begin
          m_addr = memAddr; m_wd = memDataIn;
        end else if (memAddr !== m_addr || memDataIn !== m_wd) begin
          m_hold_bad = 1'b1;
        end
        if (memRead)  m_rd = m_rd + 8'd1;
        if (memWrite) m_wr = m_wr + 8'd1;
      end
      if (outErr || o_dbg_state == 2'd3) begin
        n_events++;
        m_got = {m_hold_bad, (outErr ? K_ERR : K_DONE), m_stall, m_rd, m_wr, m_addr, m_wd, outMemoryOut};
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event: got %h expected none", m_got);
        end else begin
          m_exp = exp_q.pop_front();
          check("event", m_got, m_exp);
        end
        m_stall = 0; m_rd = 0; m_wr = 0; m_addr = 0; m_wd = 0; m_hold_bad = 0;
      end
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  // One aligned access: n_stall busy cycles in REQ, memDone k cycles after
  // acceptance (k=0: hit in the accepting cycle), or no memDone at all (to=1).
  task automatic run_op(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wd, input int n_stall, input int k,
                        input logic [15:0] rdata, input bit to);
    inMemoryRead = rd; inMemoryWrite = wr; inXOut = addr; inWriteData = wd;
    memStall = 0; memDone = 0;
    step();
    inMemoryRead = 0; inMemoryWrite = 0; inXOut = 0; inWriteData = 0;
    if (to) begin
      repeat (8) step();
    end else begin
      for (int i = 0; i < n_stall; i++) begin memStall = 1; step(); end
      memStall = 0;
      for (int i = 0; i < k; i++) step();
      memDone = 1; memDataOut = rdata;
      step();
      memDone = 0; memDataOut = 0;
    end
    step();
  endtask

  initial begin
    repeat (3) step();
    rst = 0;
    @(negedge clk);
    check("rst_stall",  {74'd0, outStall}, {74'd0, 1'b0});
    check("rst_err",    {74'd0, outErr}, {74'd0, 1'b0});
    check("rst_rdwr",   {73'd0, memRead, memWrite}, 75'd0);
    check("rst_addr",   {59'd0, memAddr}, 75'd0);
    check("rst_mout",   {59'd0, outMemoryOut}, 75'd0);
    check("rst_state",  {73'd0, o_dbg_state}, {73'd0, S_IDLE});
    @(posedge clk); #1;

    // Load hit.
    exp_q.push_back(mk(K_DONE, 8'd2, 8'd1, 8'd0, 16'h0010, 16'h0000, 16'hBEEF));
    run_op(1, 0, 16'h0010, 16'h0000, 0, 0, 16'hBEEF, 0);

    // Store with 3 busy cycles, done 2 cycles after acceptance.
    exp_q.push_back(mk(K_DONE, 8'd7, 8'd0, 8'd4, 16'h0020, 16'h1234, 16'h0000));
    run_op(0, 1, 16'h0020, 16'h1234, 3, 2, 16'h0000, 0);

    // Load miss: 1 busy cycle, done 3 cycles after acceptance.
    exp_q.push_back(mk(K_DONE, 8'd6, 8'd2, 8'd0, 16'h0100, 16'h0000, 16'hCAFE));
    run_op(1, 0, 16'h0100, 16'h0000, 1, 3, 16'hCAFE, 0);

    // Misaligned load: error pulse, no stall, no request.
    exp_q.push_back(mk(K_ERR, 8'd0, 8'd0, 8'd0, 16'h0000, 16'h0000, 16'h0000));
    inMemoryRead = 1; inXOut = 16'h0013;
    step();
    inMemoryRead = 0; inXOut = 0;
    step();

    // Timeout: error on the 8th REQ/WAIT cycle, then DONE with zero data.
    exp_q.push_back(mk(K_ERR, 8'd9, 8'd1, 8'd0, 16'h0030, 16'h0000, 16'h0000));
    exp_q.push_back(mk(K_DONE, 8'd0, 8'd0, 8'd0, 16'h0000, 16'h0000, 16'h0000));
    run_op(1, 0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 1);

    // Back-to-back: second op presented in the IDLE cycle right after DONE.
    exp_q.push_back(mk(K_DONE, 8'd2, 8'd1, 8'd0, 16'h0002, 16'h0000, 16'h00AA));
    exp_q.push_back(mk(K_DONE, 8'd3, 8'd0, 8'd1, 16'h0004, 16'h5A5A, 16'h0000));
    run_op(1, 0, 16'h0002, 16'h0000, 0, 0, 16'h00AA, 0);
    run_op(0, 1, 16'h0004, 16'h5A5A, 0, 1, 16'h0000, 0);

    // Reset while in WAIT, then a late memDone that must be ignored.
    begin
      int ev0;
      ev0 = n_events;
      inMemoryRead = 1; inXOut = 16'h0040;
      step();
      inMemoryRead = 0; inXOut = 0;
      step();
      rst = 1;
      step();
      rst = 0; memDone = 1; memDataOut = 16'h7777;
      @(negedge clk);
      check("midrst_state", {73'd0, o_dbg_state}, {73'd0, S_IDLE});
      check("midrst_stall", {74'd0, outStall}, 75'd0);
      @(posedge clk); #1;
      memDone = 0; memDataOut = 0;
      repeat (3) step();
      check("midrst_no_done", 75'(n_events - ev0), 75'd0);
    end

    repeat (2) step();
    check("queue_empty", 75'(exp_q.size()), 75'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Memory stage of the five-stage pipeline, between the EX/MEM register and the MEM/WB register. It runs one data-memory load or store per instruction against a multi-cycle memory with a stall/done handshake, stalls the front of the pipeline while the access is outstanding, and delivers the load data to MEM/WB. It also flags misaligned accesses and memory timeouts.

## Interface
- TIMEOUT_CYCLES, 64: maximum number of cycles spent in REQ+WAIT before the access is abandoned; legal range 1..255.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- inXOut  in  16  ALU result from EX/MEM, used as the byte address.
- inWriteData  in  16  store data from EX/MEM.
- inMemoryRead  in  1  the instruction is a load.
- inMemoryWrite  in  1  the instruction is a store; never asserted together with inMemoryRead.
- memStall  in  1  memory busy; the request is not accepted this cycle.
- memDone  in  1  one-cycle pulse: the access has completed; memDataOut is valid for loads.
- memDataOut  in  16  read data from memory.
- memAddr  out  16  address to memory.
- memDataIn  out  16  write data to memory.
- memRead  out  1  read request.
- memWrite  out  1  write request.
- outMemoryOut  out  16  load data toward MEM/WB.
- outStall  out  1  holds PC, IF/ID, ID/EX and EX/MEM; inserts a bubble into MEM/WB.
- outErr  out  1  one-cycle error pulse (misaligned address or timeout).

## Operation
- The FSM has four states: IDLE, REQ, WAIT, DONE. Internal registers: addrReg[15:0], dataReg[15:0], rdReg, wrReg, loadReg[15:0], timeoutCnt[7:0].
- **IDLE**
  - No op (inMemoryRead=inMemoryWrite=0): outStall=0, outMemoryOut=0; stay in IDLE.
  - Op with inXOut[0]=1 (misaligned): no memory request; outErr=1 and outStall=0 this cycle; outMemoryOut=0; stay in IDLE.
  - Op with an aligned address: latch inXOut, inWriteData, rd and wr; clear timeoutCnt; outStall=1; next state REQ.
- **REQ**
  - Drive memAddr=addrReg. Drive memDataIn=dataReg. Drive memRead=rdReg and memWrite=wrReg. outStall=1.
  - If memStall=1: stay in REQ.
  - Else if memDone=1 (hit): loadReg ← rdReg ? memDataOut : 0; next state DONE.
  - Else: next state WAIT.
- **WAIT**
  - memRead=memWrite=0. outStall=1.
  - If memDone=1: capture loadReg as in REQ; next state DONE.
- **DONE**
  - outStall=0. outMemoryOut=loadReg. Inputs are ignored.
  - Next state is always IDLE.
- **Timeout**
  - timeoutCnt increments each cycle spent in REQ or WAIT.
  - When timeoutCnt reaches TIMEOUT_CYCLES-1 and memDone=0, the access is abandoned: outErr=1 that cycle, loadReg ← 0, next state DONE.
  - memDone arriving in that same cycle takes priority over the timeout: normal completion, no error.
- **Idle outputs:** memAddr, memDataIn, memRead and memWrite are 0 in IDLE, WAIT and DONE.

## Timing
- **Reset:** state IDLE; all registers 0. All outputs are 0 in the first cycle after reset.
- **Mid-access reset:** rst asserted during an access returns the FSM to IDLE on that edge. memRead/memWrite drop the next cycle, and any later memDone is ignored.
- **Combinational outputs:** outStall and outErr are combinational from state and inputs, so the pipeline sees them in the same cycle.
- **Minimum latency:** op seen in IDLE at cycle t, memDone together with acceptance at t+1, DONE at t+2. That is 2 stall cycles. EX/MEM advances on the edge ending t+2.
- **Miss latency:** a miss completing k cycles after acceptance gives 2+k stall cycles.
- **Back-to-back ops:** a new op appears in IDLE the cycle after DONE. No dead cycle is needed beyond DONE.
- **Request hold:** the request is held stable in REQ through any number of memStall cycles. Each access is accepted exactly once.
- **Stray pulses:** memDone in IDLE or DONE is ignored.

## Test plan
- **Load hit:** reset, then load inXOut=0x0010 with memStall=0 and memDone=1/memDataOut=0xBEEF at the REQ cycle. Expect outStall=1 for 2 cycles, then outMemoryOut=0xBEEF with outStall=0 in DONE, and memRead high for exactly 1 cycle.
- **Store with busy memory:** store addr 0x0020, data 0x1234, memStall=1 for 3 cycles, memDone 2 cycles after acceptance. Expect memWrite/memAddr=0x0020/memDataIn=0x1234 held 4 cycles, 7 stall cycles total, outMemoryOut=0 in DONE.
- **Misaligned access:** load at 0x0013. Expect outErr=1 for one cycle, outStall=0, memRead never asserted.
- **Timeout:** TIMEOUT_CYCLES=8, load accepted and memDone never pulses. Expect outErr pulse on the 8th REQ/WAIT cycle, then DONE with outMemoryOut=0, then IDLE.
- **Reset mid-WAIT:** assert rst in WAIT, then pulse memDone one cycle later. Expect state IDLE, outStall=0 and no DONE.
- **Back-to-back:** load(0x0002 → 0x00AA) followed immediately by store(0x0004). Expect the second request to start the cycle after DONE, with the first outMemoryOut=0x00AA.
